axis_pkt_arbiter: RTL

AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

---
 rtl/axis_pkt_arb_pkg.sv | 27 ++
 rtl/axis_pkt_reg_slice.sv | 73 +++++++
 rtl/axis_pkt_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/axis_pkt_arb_pkg.sv
// Shared types and widths for the two-requester AXI-Stream packet arbiter.
package axis_pkt_arb_pkg;

  // Encoded so that the grant states map directly onto the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  localparam int LEN_W = 16;
  localparam int SPT_W = 8;
  localparam int DPT_W = 8;

  // One-hot grant presented to the consumer; 00 while idle.
  function automatic logic [1:0] state_to_gnt(arb_state_t s);
    logic [1:0] g;
    g = 2'b00;
    case (s)
      GNT0:    g = 2'b01;
      GNT1:    g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/axis_pkt_reg_slice.sv
// Single forward register stage for the merged stream: data, strobes, last
// and all sidebands are captured together so they always describe one beat.
module axis_pkt_reg_slice
  import axis_pkt_arb_pkg::*;
#(
  parameter int DAT_W = 256
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               i_load,
  input  logic               i_ready,
  input  logic [DAT_W-1:0]   i_tdata,
  input  logic [DAT_W/8-1:0] i_tstrb,
  input  logic               i_tlast,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [SPT_W-1:0]   i_spt,
  input  logic [DPT_W-1:0]   i_dpt,
  input  logic               i_err,
  output logic               o_tvalid,
  output logic [DAT_W-1:0]   o_tdata,
  output logic [DAT_W/8-1:0] o_tstrb,
  output logic               o_tlast,
  output logic [LEN_W-1:0]   o_len,
  output logic [SPT_W-1:0]   o_spt,
  output logic [DPT_W-1:0]   o_dpt,
  output logic               o_err
);

  logic               r_tvalid;
  logic [DAT_W-1:0]   r_tdata;
  logic [DAT_W/8-1:0] r_tstrb;
  logic               r_tlast;
  logic [LEN_W-1:0]   r_len;
  logic [SPT_W-1:0]   r_spt;
  logic [DPT_W-1:0]   r_dpt;
  logic               r_err;

  // Load a new beat when offered, otherwise drop valid once the consumer takes it;
  // the payload is only rewritten on a load, so it holds during back-pressure.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tstrb  <= '0;
      r_tlast  <= 1'b0;
      r_len    <= '0;
      r_spt    <= '0;
      r_dpt    <= '0;
      r_err    <= 1'b0;
    end else if (i_load) begin
      r_tvalid <= 1'b1;
      r_tdata  <= i_tdata;
      r_tstrb  <= i_tstrb;
      r_tlast  <= i_tlast;
      r_len    <= i_len;
      r_spt    <= i_spt;
      r_dpt    <= i_dpt;
      r_err    <= i_err;
    end else if (i_ready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign o_tvalid = r_tvalid;
  assign o_tdata  = r_tdata;
  assign o_tstrb  = r_tstrb;
  assign o_tlast  = r_tlast;
  assign o_len    = r_len;
  assign o_spt    = r_spt;
  assign o_dpt    = r_dpt;
  assign o_err    = r_err;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Two-requester AXI-Stream packet arbiter with packet-granular round-robin
// grant and a single output register stage.
// Optional per-requester packet counters: define AXIS_PKT_ARB_STATS_EN.
module axis_pkt_arbiter
  import axis_pkt_arb_pkg::*;
#(
  parameter int DAT_W = 256
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [DAT_W-1:0]   S0_AXIS_DAT_TDATA,
  input  logic [DAT_W/8-1:0] S0_AXIS_DAT_TSTRB,
  input  logic               S0_AXIS_DAT_TVALID,
  input  logic               S0_AXIS_DAT_TLAST,
  output logic               S0_AXIS_DAT_TREADY,
  input  logic [LEN_W-1:0]   S0_AXIS_LEN_TDATA,
  input  logic [SPT_W-1:0]   S0_AXIS_SPT_TDATA,
  input  logic [DPT_W-1:0]   S0_AXIS_DPT_TDATA,
  input  logic               S0_AXIS_ERR_TVALID,
  input  logic [DAT_W-1:0]   S1_AXIS_DAT_TDATA,
  input  logic [DAT_W/8-1:0] S1_AXIS_DAT_TSTRB,
  input  logic               S1_AXIS_DAT_TVALID,
  input  logic               S1_AXIS_DAT_TLAST,
  output logic               S1_AXIS_DAT_TREADY,
  input  logic [LEN_W-1:0]   S1_AXIS_LEN_TDATA,
  input  logic [SPT_W-1:0]   S1_AXIS_SPT_TDATA,
  input  logic [DPT_W-1:0]   S1_AXIS_DPT_TDATA,
  input  logic               S1_AXIS_ERR_TVALID,
  output logic [DAT_W-1:0]   M_AXIS_DAT_TDATA,
  output logic [DAT_W/8-1:0] M_AXIS_DAT_TSTRB,
  output logic               M_AXIS_DAT_TVALID,
  output logic               M_AXIS_DAT_TLAST,
  input  logic               M_AXIS_DAT_TREADY,
  output logic [LEN_W-1:0]   M_AXIS_LEN_TDATA,
  output logic [SPT_W-1:0]   M_AXIS_SPT_TDATA,
  output logic [DPT_W-1:0]   M_AXIS_DPT_TDATA,
  output logic               M_AXIS_ERR_TVALID,
  output logic [1:0]         M_AXIS_GNT
`ifdef AXIS_PKT_ARB_STATS_EN
  ,
  output logic [31:0]        PKT_CNT0,
  output logic [31:0]        PKT_CNT1
`endif
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic       r_last_s1;   // 1: requester 1 was granted most recently
  logic       w_m_tvalid;
  logic       w_ld_ok;
  logic       w_sel1;
  logic       w_load;
  logic [1:0] w_tvalid;
  logic [1:0] w_tlast;
  logic [1:0] w_tready;
  logic [1:0] w_acc;
  logic [1:0] w_gnt;

  assign w_tvalid = {S1_AXIS_DAT_TVALID, S0_AXIS_DAT_TVALID};
  assign w_tlast  = {S1_AXIS_DAT_TLAST,  S0_AXIS_DAT_TLAST};
  // The output register can take a beat when empty or being drained this cycle.
  assign w_ld_ok  = !w_m_tvalid || M_AXIS_DAT_TREADY;

  // State register plus round-robin pointer, which moves when a grant is issued.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state   <= IDLE;
      r_last_s1 <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_state_next != IDLE)
        r_last_s1 <= (w_state_next == GNT1);
    end
  end

  // Next-state decode and handshake outputs; grants only end on an accepted TLAST.
  always_comb begin
    w_state_next = r_state;
    w_tready     = 2'b00;
    w_gnt        = state_to_gnt(r_state);
    case (r_state)
      IDLE: begin
        if (w_tvalid[0] && w_tvalid[1])
          w_state_next = r_last_s1 ? GNT0 : GNT1;
        else if (w_tvalid[0])
          w_state_next = GNT0;
        else if (w_tvalid[1])
          w_state_next = GNT1;
      end
      GNT0: begin
        w_tready[0] = w_ld_ok;
        if (w_tvalid[0] && w_ld_ok && w_tlast[0])
          w_state_next = IDLE;
      end
      GNT1: begin
        w_tready[1] = w_ld_ok;
        if (w_tvalid[1] && w_ld_ok && w_tlast[1])
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_acc  = w_tvalid & w_tready;
  assign w_load = |w_acc;
  assign w_sel1 = (r_state == GNT1);

  assign S0_AXIS_DAT_TREADY = w_tready[0];
  assign S1_AXIS_DAT_TREADY = w_tready[1];
  assign M_AXIS_GNT         = w_gnt;
  assign M_AXIS_DAT_TVALID  = w_m_tvalid;

  axis_pkt_reg_slice #(
    .DAT_W (DAT_W)
  ) u_slice (
    .clk      (ACLK),
    .srst     (ARESET),
    .i_load   (w_load),
    .i_ready  (M_AXIS_DAT_TREADY),
    .i_tdata  (w_sel1 ? S1_AXIS_DAT_TDATA  : S0_AXIS_DAT_TDATA),
    .i_tstrb  (w_sel1 ? S1_AXIS_DAT_TSTRB  : S0_AXIS_DAT_TSTRB),
    .i_tlast  (w_sel1 ? S1_AXIS_DAT_TLAST  : S0_AXIS_DAT_TLAST),
    .i_len    (w_sel1 ? S1_AXIS_LEN_TDATA  : S0_AXIS_LEN_TDATA),
    .i_spt    (w_sel1 ? S1_AXIS_SPT_TDATA  : S0_AXIS_SPT_TDATA),
    .i_dpt    (w_sel1 ? S1_AXIS_DPT_TDATA  : S0_AXIS_DPT_TDATA),
    .i_err    (w_sel1 ? S1_AXIS_ERR_TVALID : S0_AXIS_ERR_TVALID),
    .o_tvalid (w_m_tvalid),
    .o_tdata  (M_AXIS_DAT_TDATA),
    .o_tstrb  (M_AXIS_DAT_TSTRB),
    .o_tlast  (M_AXIS_DAT_TLAST),
    .o_len    (M_AXIS_LEN_TDATA),
    .o_spt    (M_AXIS_SPT_TDATA),
    .o_dpt    (M_AXIS_DPT_TDATA),
    .o_err    (M_AXIS_ERR_TVALID)
  );

`ifdef AXIS_PKT_ARB_STATS_EN
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] r_pkt_cnt;
      // Count completed packets per requester; natural 32-bit wrap.
      always_ff @(posedge ACLK) begin
        if (ARESET)
          r_pkt_cnt <= '0;
        else if (w_acc[gi] && w_tlast[gi])
          r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
    end
  endgenerate

  assign PKT_CNT0 = g_cnt[0].r_pkt_cnt;
  assign PKT_CNT1 = g_cnt[1].r_pkt_cnt;
`endif

endmodule
